// File: rtl/spram_pkg.sv
`default_nettype none
// ============================================================================
// Module : spram_pkg
// Brief  : Shared types and constants for the SPRAM bus arbiter slice.
//          - arb_state_t : top-level phase (BOOT -> HOLD -> RUN)
//          - rd_tag_t    : which port owns the read currently in flight
//          - WP_TOP_WORD : first word address outside the protected boot
//                          image (used when SPRAM_WRITE_PROTECT_EN is defined)
// Rev    : 1.0  initial release
// ============================================================================
package spram_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2
    } rd_tag_t;

    // Boot image occupies word addresses [0, WP_TOP_WORD), i.e. 1 KiB.
    localparam int unsigned WP_TOP_WORD = 32'd256;

endpackage
`default_nettype wire

// File: rtl/spram_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : spram_bus_arbiter_if
// Brief  : CPU-side bus bundle of the SPRAM arbiter.
//          Instruction port: i_req/i_addr -> i_ack, i_rvalid, i_rdata
//          Data port       : d_req/d_addr/d_we/d_wdat -> d_ack, d_rvalid, d_rdata
//          Addresses are word addresses (ADDR_BITS-2 bits).
//          modport master : CPU side (drives requests)
//          modport slave  : arbiter side (drives acks and read data)
// Rev    : 1.0  initial release
// ============================================================================
interface spram_bus_arbiter_if #(
    parameter int ADDR_BITS = 16
);
    logic                 i_req;
    logic [ADDR_BITS-3:0] i_addr;
    logic                 i_ack;
    logic                 i_rvalid;
    logic [31:0]          i_rdata;

    logic                 d_req;
    logic [ADDR_BITS-3:0] d_addr;
    logic [3:0]           d_we;
    logic [31:0]          d_wdat;
    logic                 d_ack;
    logic                 d_rvalid;
    logic [31:0]          d_rdata;

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rvalid, i_rdata,
        output d_req, d_addr, d_we, d_wdat,
        input  d_ack, d_rvalid, d_rdata
    );

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rvalid, i_rdata,
        input  d_req, d_addr, d_we, d_wdat,
        output d_ack, d_rvalid, d_rdata
    );
endinterface
`default_nettype wire

// File: rtl/spram_cpu_reset_gen.sv
`default_nettype none
// ============================================================================
// Module : spram_cpu_reset_gen
// Brief  : Boot sequencer. Latches init_done, counts RESET_HOLD cycles in
//          HOLD, then enters RUN for good and releases the CPU reset.
// Ports  : clk, rstn (async, active low)
//          init_done in  : loader finished (level, latched)
//          state     out : current phase (BOOT/HOLD/RUN)
//          run_en    out : 1 while in RUN
//          cpu_rstn  out : registered CPU reset, high from the first RUN cycle
// Rev    : 1.0  initial release
// ============================================================================
module spram_cpu_reset_gen
    import spram_pkg::*;
#(
    parameter int RESET_HOLD = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       init_done,
    output arb_state_t state,
    output logic       run_en,
    output logic       cpu_rstn
);
    localparam int              CNT_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_HOLD - 1);

    arb_state_t       state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic             done_latched;
    logic             done_latched_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= BOOT;
            hold_cnt     <= '0;
            done_latched <= 1'b0;
            cpu_rstn     <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            done_latched <= done_latched_nxt;
            // Registered so the release lines up with the first RUN cycle.
            cpu_rstn     <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt        = state;
        hold_cnt_nxt     = hold_cnt;
        done_latched_nxt = done_latched | init_done;
        unique case (state)
            BOOT: begin
                if (done_latched_nxt) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = '0;
                end
            end
            HOLD: begin
                if (hold_cnt == CNT_LAST) begin
                    state_nxt = RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign run_en = (state == RUN);

endmodule
`default_nettype wire

// File: rtl/spram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : spram_bus_arbiter
// Brief  : Owns the SPRAM port. In BOOT the loader's writes pass straight
//          through and the CPU is held in reset; after init_done and a fixed
//          hold the CPU is released and SPRAM is shared between an
//          instruction-fetch port (read only) and a data port (byte-strobed
//          read/write), one access per cycle, data priority with an
//          anti-starvation override for instruction fetch.
// Ports  : clk, rstn                 clock, async active-low reset
//          init_we/addr/wdat/done    boot loader side
//          cpu_rstn                  CPU reset (active low, registered)
//          bus (slave modport)       instruction and data ports
//          spram_we/addr/wdat/rdat   SPRAM macro port
//          wp_fault                  sticky write-protect violation
// Config : SPRAM_WRITE_PROTECT_EN - when defined, data writes below
//          WP_TOP_WORD are acked but dropped and set wp_fault; otherwise
//          every write passes and wp_fault is tied low.
// Rev    : 1.0  initial release
// ============================================================================
module spram_bus_arbiter
    import spram_pkg::*;
#(
    parameter int ADDR_BITS    = 16,
    parameter int RESET_HOLD   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [3:0]           init_we,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [31:0]          init_wdat,
    input  logic                 init_done,
    output logic                 cpu_rstn,
    spram_bus_arbiter_if.slave   bus,
    output logic [3:0]           spram_we,
    output logic [ADDR_BITS-1:0] spram_addr,
    output logic [31:0]          spram_wdat,
    input  logic [31:0]          spram_rdat,
    output logic                 wp_fault
);
    localparam int               SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]  SC_MAX = SC_W'(STARVE_LIMIT);

    arb_state_t           state;
    logic                 run_en;
    logic [SC_W-1:0]      starve_cnt;
    logic                 instr_starved;
    logic                 grant_i;
    logic                 grant_d;
    logic                 d_is_write;
    logic                 d_wp_block;
    rd_tag_t              rd_tag;
    rd_tag_t              rd_tag_nxt;
    logic [ADDR_BITS-1:0] last_addr;
    logic [31:0]          i_rdata_q;
    logic [31:0]          d_rdata_q;

    spram_cpu_reset_gen #(
        .RESET_HOLD (RESET_HOLD)
    ) u_reset_gen (
        .clk       (clk),
        .rstn      (rstn),
        .init_done (init_done),
        .state     (state),
        .run_en    (run_en),
        .cpu_rstn  (cpu_rstn)
    );

    // ------------------------------------------------------------------
    // Arbitration: data has priority unless instr has been denied
    // STARVE_LIMIT cycles in a row.
    // ------------------------------------------------------------------
    assign instr_starved = (starve_cnt == SC_MAX);
    assign grant_i       = run_en & bus.i_req & (~bus.d_req | instr_starved);
    assign grant_d       = run_en & bus.d_req & ~grant_i;
    assign d_is_write    = |bus.d_we;

`ifdef SPRAM_WRITE_PROTECT_EN
    logic wp_fault_q;
    assign d_wp_block = grant_d & d_is_write & (32'(bus.d_addr) < WP_TOP_WORD);
    assign wp_fault   = wp_fault_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_fault_q <= 1'b0;
        end else if (d_wp_block) begin
            wp_fault_q <= 1'b1;
        end
    end
`else
    assign d_wp_block = 1'b0;
    assign wp_fault   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // SPRAM port mux. With no winner the address is held so the macro
    // sees no spurious toggling.
    // ------------------------------------------------------------------
    always_comb begin
        spram_we   = 4'h0;
        spram_addr = last_addr;
        spram_wdat = 32'h0;
        if (state == BOOT) begin
            spram_we   = init_we;
            spram_addr = init_addr;
            spram_wdat = init_wdat;
        end else if (grant_i) begin
            spram_addr = {bus.i_addr, 2'b00};
        end else if (grant_d) begin
            spram_addr = {bus.d_addr, 2'b00};
            spram_wdat = bus.d_wdat;
            spram_we   = d_wp_block ? 4'h0 : bus.d_we;
        end
    end

    // Tag of the read issued this cycle; the data returns next cycle.
    always_comb begin
        rd_tag_nxt = TAG_NONE;
        if (grant_i) begin
            rd_tag_nxt = TAG_I;
        end else if (grant_d && !d_is_write) begin
            rd_tag_nxt = TAG_D;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
            rd_tag     <= TAG_NONE;
            last_addr  <= '0;
            i_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            last_addr <= spram_addr;
            rd_tag    <= rd_tag_nxt;

            // Counts consecutive denied instr cycles; holds while idle.
            if (grant_i) begin
                starve_cnt <= '0;
            end else if (run_en && bus.i_req && !instr_starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (rd_tag == TAG_I) begin
                i_rdata_q <= spram_rdat;
            end
            if (rd_tag == TAG_D) begin
                d_rdata_q <= spram_rdat;
            end
        end
    end

    assign bus.i_ack    = grant_i;
    assign bus.d_ack    = grant_d;
    assign bus.i_rvalid = (rd_tag == TAG_I);
    assign bus.d_rvalid = (rd_tag == TAG_D);
    // Fresh data is presented in the rvalid cycle, then held in the register.
    assign bus.i_rdata  = bus.i_rvalid ? spram_rdat : i_rdata_q;
    assign bus.d_rdata  = bus.d_rvalid ? spram_rdat : d_rdata_q;

endmodule
`default_nettype wire
